// File: rtl/nrdiv8_pkg.sv
// nrdiv8_pkg: shared widths, FSM state encoding and control-strobe bundle for
// the nrdiv8 unsigned non-restoring divider (16-bit / 8-bit -> 8q, 8r).
// Optional feature macro used by the design: NRDIV8_OVF_CHECK_EN.
package nrdiv8_pkg;

  localparam int unsigned W_OP    = 8;
  localparam int unsigned W_ACC   = 9;
  localparam int unsigned N_STEPS = 8;
  localparam int unsigned W_CNT   = $clog2(N_STEPS);

  typedef enum logic [2:0] {
    IDLE,
    LD_Q,
    LD_M,
    CHK,
    STEP,
    CORR,
    OUT_R,
    OUT_Q
  } state_e;

  // One-hot register enables / phase strobes from the control unit.
  typedef struct packed {
    logic ld_a;
    logic ld_q;
    logic ld_m;
    logic chk;
    logic step;
    logic corr;
    logic out_r;
    logic out_q;
  } strobe_t;

endpackage

// File: rtl/nrdiv8_if.sv
// nrdiv8_if: byte-serial operand/result bus of the divider.
//   bgn    : start request (master -> slave)
//   inbus  : operand bytes: dividend high, dividend low, divisor
//   done   : result framing, high for the two result cycles
//   err    : overflow / divide-by-zero flag during result cycles
//   outbus : remainder then quotient, 8'h00 otherwise
interface nrdiv8_if;
  logic                         bgn;
  logic [nrdiv8_pkg::W_OP-1:0]  inbus;
  logic                         done;
  logic                         err;
  logic [nrdiv8_pkg::W_OP-1:0]  outbus;

  modport master (output bgn, inbus, input done, err, outbus);
  modport slave  (input bgn, inbus, output done, err, outbus);
endinterface

// File: rtl/nrdiv8_cu.sv
// nrdiv8_cu: divider control unit (FSM + step counter).
//   clk, rst_b : clock, synchronous active-high reset
//   bgn_i      : start request, honoured only in IDLE
//   ovf_i      : overflow verdict from the datapath, used in CHK
//   a_sign_i   : accumulator sign bit A[8] before this cycle's update
//   stb_o      : one-hot phase strobes / register enables
//   sub_o      : 1 = subtract divisor, 0 = add divisor
module nrdiv8_cu
  import nrdiv8_pkg::*;
(
  input  logic    clk,
  input  logic    rst_b,
  input  logic    bgn_i,
  input  logic    ovf_i,
  input  logic    a_sign_i,
  output strobe_t stb_o,
  output logic    sub_o
);

  state_e             state_q, state_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_o   = '0;
    sub_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bgn_i) begin
          stb_o.ld_a = 1'b1;
          state_d    = LD_Q;
        end
      end
      LD_Q: begin
        stb_o.ld_q = 1'b1;
        state_d    = LD_M;
      end
      LD_M: begin
        stb_o.ld_m = 1'b1;
        cnt_d      = '0;
        state_d    = CHK;
      end
      CHK: begin
        stb_o.chk = 1'b1;
        state_d   = ovf_i ? OUT_R : STEP;
      end
      STEP: begin
        stb_o.step = 1'b1;
        // Non-restoring: subtract while the partial remainder is non-negative.
        sub_o      = ~a_sign_i;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == W_CNT'(N_STEPS - 1)) state_d = CORR;
      end
      CORR: begin
        stb_o.corr = 1'b1;
        state_d    = OUT_R;
      end
      OUT_R: begin
        stb_o.out_r = 1'b1;
        state_d     = OUT_Q;
      end
      OUT_Q: begin
        stb_o.out_q = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/nrdiv8.sv
// nrdiv8: unsigned non-restoring sequential divider, 16-bit dividend by
// 8-bit divisor -> 8-bit quotient and 8-bit remainder, byte-serial I/O.
//   clk   : rising-edge clock
//   rst_b : synchronous reset, active HIGH despite the name
//   bus   : nrdiv8_if slave (bgn, inbus in; done, err, outbus out)
// Build option: define NRDIV8_OVF_CHECK_EN to enable the overflow /
// divide-by-zero check in CHK and the err output; otherwise err is 0 and
// overflowing inputs simply run through the algorithm.
module nrdiv8
  import nrdiv8_pkg::*;
(
  input  logic     clk,
  input  logic     rst_b,
  nrdiv8_if.slave  bus
);

  logic [W_ACC-1:0] a_q, a_d;
  logic [W_OP-1:0]  q_q, q_d;
  logic [W_OP-1:0]  m_q, m_d;
  logic             ovf_q, ovf_d;
  logic             ovf_chk;
  strobe_t          stb;
  logic             sub;

  nrdiv8_cu u_cu (
    .clk      (clk),
    .rst_b    (rst_b),
    .bgn_i    (bus.bgn),
    .ovf_i    (ovf_chk),
    .a_sign_i (a_q[W_ACC-1]),
    .stb_o    (stb),
    .sub_o    (sub)
  );

`ifdef NRDIV8_OVF_CHECK_EN
  // Dividend high byte >= divisor means the quotient needs more than 8 bits.
  always_comb ovf_chk = (m_q == '0) || (a_q[W_OP-1:0] >= m_q);
`else
  always_comb ovf_chk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_b) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    logic [W_ACC-1:0] sh;
    logic [W_ACC-1:0] a_new;
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    ovf_d = ovf_q;
    sh    = {a_q[W_OP-1:0], q_q[W_OP-1]};
    a_new = sub ? (sh - {1'b0, m_q}) : (sh + {1'b0, m_q});
    if (stb.ld_a) a_d   = {1'b0, bus.inbus};
    if (stb.ld_q) q_d   = bus.inbus;
    if (stb.ld_m) m_d   = bus.inbus;
    if (stb.chk)  ovf_d = ovf_chk;
    if (stb.step) begin
      a_d = a_new;
      q_d = {q_q[W_OP-2:0], ~a_new[W_ACC-1]};
    end
    // Final restore of a negative partial remainder.
    if (stb.corr && a_q[W_ACC-1]) a_d = a_q + {1'b0, m_q};
  end

  always_comb begin
    bus.done   = stb.out_r | stb.out_q;
`ifdef NRDIV8_OVF_CHECK_EN
    bus.err    = (stb.out_r | stb.out_q) & ovf_q;
`else
    bus.err    = 1'b0;
`endif
    bus.outbus = '0;
    if (stb.out_r) bus.outbus = ovf_q ? '0 : a_q[W_OP-1:0];
    if (stb.out_q) bus.outbus = ovf_q ? '1 : q_q;
  end

endmodule

// File: tb/tb_nrdiv8.sv
// tb_nrdiv8: self-checking bench for nrdiv8; reference results come from
// plain integer division of the operands.
module tb_nrdiv8;

  logic clk = 1'b0;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  nrdiv8_if bus ();

  nrdiv8 dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge while the DUT is in IDLE (that cycle is cycle 0);
  // returns at the falling edge of the first IDLE cycle after the result.
  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                        input bit hold_bgn);
    int  k;
    bit  ovf;
    bit  chk_vals;
    int  exp_q, exp_r, exp_cyc;
    bit  exp_err;
    ovf = (dvs == 0) || ((int'(dvd) / int'(dvs)) > 255);
`ifdef NRDIV8_OVF_CHECK_EN
    exp_err  = ovf;
    exp_cyc  = ovf ? 4 : 13;
    chk_vals = 1'b1;
    exp_r    = ovf ? 0   : int'(dvd) % int'(dvs);
    exp_q    = ovf ? 255 : int'(dvd) / int'(dvs);
`else
    exp_err  = 1'b0;
    exp_cyc  = 13;
    chk_vals = !ovf;
    exp_r    = ovf ? 0 : int'(dvd) % int'(dvs);
    exp_q    = ovf ? 0 : int'(dvd) / int'(dvs);
`endif
    bus.bgn   = 1'b1;
    bus.inbus = dvd[15:8];
    @(negedge clk);
    bus.bgn   = hold_bgn;
    bus.inbus = dvd[7:0];
    @(negedge clk);
    bus.inbus = dvs;
    k = 2;
    do begin
      @(negedge clk);
      k++;
      if (hold_bgn) bus.inbus = 8'($urandom);
      else          bus.inbus = 8'hxx;
    end while (!bus.done && k < 30);
    chk({tag, "_done_cyc"}, 16'(k), 16'(exp_cyc));
    chk({tag, "_err_r"}, 16'(bus.err), 16'(exp_err));
    if (chk_vals) chk({tag, "_rem"}, 16'(bus.outbus), 16'(exp_r));
    @(negedge clk);
    chk({tag, "_done_q"}, 16'(bus.done), 16'd1);
    chk({tag, "_err_q"}, 16'(bus.err), 16'(exp_err));
    if (chk_vals) chk({tag, "_quot"}, 16'(bus.outbus), 16'(exp_q));
    @(negedge clk);
    chk({tag, "_done_end"}, 16'(bus.done), 16'd0);
    chk({tag, "_out_end"}, 16'(bus.outbus), 16'd0);
  endtask

  initial begin
    logic [7:0]  dvs;
    logic [15:0] dvd;
    rst_b     = 1'b1;
    bus.bgn   = 1'b0;
    bus.inbus = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_err", 16'(bus.err), 16'd0);
    chk("rst_out", 16'(bus.outbus), 16'd0);
    rst_b = 1'b0;
    @(negedge clk);

    run_op("t100_7", 16'h0064, 8'h07, 1'b0);
    run_op("t12345_200", 16'h3039, 8'hC8, 1'b0);
    run_op("tmaxq", 16'hFEFF, 8'hFF, 1'b0);
    run_op("tdiv0", 16'h1234, 8'h00, 1'b0);
    run_op("tovf", 16'h0100, 8'h01, 1'b0);

    // Reset during STEP (cycle 7) aborts the operation.
    bus.bgn = 1'b1; bus.inbus = 8'h00;
    @(negedge clk); bus.bgn = 1'b0; bus.inbus = 8'h64;
    @(negedge clk); bus.inbus = 8'h07;
    repeat (5) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("mid_rst_done", 16'(bus.done), 16'd0);
    chk("mid_rst_out", 16'(bus.outbus), 16'd0);
    run_op("after_rst", 16'h0064, 8'h07, 1'b0);

    // bgn held high with noise on inbus: back-to-back ops start in cycle 15.
    run_op("hold1", 16'h0064, 8'h07, 1'b1);
    run_op("hold2", 16'h3039, 8'hC8, 1'b1);
    bus.bgn = 1'b0;
    @(negedge clk);

    for (int unsigned i = 0; i < 24; i++) begin
      dvs = 8'($urandom_range(1, 255));
      dvd = {8'($urandom_range(0, int'(dvs) - 1)), 8'($urandom)};
      run_op("rand", dvd, dvs, 1'b0);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      dvs = 8'($urandom_range(0, 127));
      dvd = {8'($urandom_range(int'(dvs), 255)), 8'($urandom)};
      run_op("rand_ovf", dvd, dvs, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
